// File: rtl/matmul_pkg.sv
// Shared types and defaults for the matmul tile scheduler and its helpers.
package matmul_pkg;

    localparam int unsigned DefaultTw      = 8;
    localparam int unsigned DefaultTimeout = 64;
    // Widest coordinate carried in tile_coord_t; instances use TW <= CoordW.
    localparam int unsigned CoordW         = 16;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StRelease,
        StOut,
        StDrain
    } sched_state_t;

    typedef struct packed {
        logic [CoordW-1:0] row;
        logic [CoordW-1:0] col;
    } tile_coord_t;

endpackage

// File: rtl/matmul_tile_walker.sv
// Row-major tile coordinate walker: load bounds, advance with column wrap, flag the final tile.
module tile_walker
    import matmul_pkg::*;
#(
    parameter int unsigned TW = DefaultTw
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          advance,
    input  logic [TW-1:0] m_tiles,
    input  logic [TW-1:0] n_tiles,
    output tile_coord_t   coord,
    output logic          last
);

    localparam logic [TW-1:0] One = {{(TW-1){1'b0}}, 1'b1};

    logic [TW-1:0] row_q, row_d;
    logic [TW-1:0] col_q, col_d;
    logic [TW-1:0] m_q, m_d;
    logic [TW-1:0] n_q, n_d;
    logic          col_end;

    assign col_end = (col_q == n_q - One);

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        m_d   = m_q;
        n_d   = n_q;
        if (load) begin
            row_d = '0;
            col_d = '0;
            m_d   = m_tiles;
            n_d   = n_tiles;
        end else if (advance) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_q + One;
            end else begin
                col_d = col_q + One;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
            m_q   <= '0;
            n_q   <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            m_q   <= m_d;
            n_q   <= n_d;
        end
    end

    assign last      = (row_q == m_q - One) && col_end;
    assign coord.row = CoordW'(row_q);
    assign coord.col = CoordW'(col_q);

endmodule

// File: rtl/matmul_tile_scheduler.sv
// Walks the output tiles of a job, runs the shared engine once per tile and emits one
// coordinate-tagged result token per tile, with per-tile timeout and abort handling.
module matmul_tile_scheduler
    import matmul_pkg::*;
#(
    parameter int unsigned TW      = DefaultTw,
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          job_valid,
    output logic          job_ready,
    input  logic [TW-1:0] job_m_tiles,
    input  logic [TW-1:0] job_n_tiles,
    input  logic          abort,
    output logic          eng_start,
    input  logic          eng_done,
    output logic [TW-1:0] tile_row,
    output logic [TW-1:0] tile_col,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [TW-1:0] res_row,
    output logic [TW-1:0] res_col,
    output logic          res_last,
    output logic          job_done,
    output logic          busy,
    output logic          err_timeout
);

    localparam int unsigned     CntW   = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    sched_state_t    state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            done_q, done_d;
    logic            walk_load, walk_adv;
    tile_coord_t     coord;
    logic            walk_last;

    tile_walker #(
        .TW (TW)
    ) u_walker (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (walk_load),
        .advance (walk_adv),
        .m_tiles (job_m_tiles),
        .n_tiles (job_n_tiles),
        .coord   (coord),
        .last    (walk_last)
    );

    // abort is evaluated ahead of every other transition in each state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        done_d    = 1'b0;
        walk_load = 1'b0;
        walk_adv  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (job_valid && !abort) begin
                    walk_load = 1'b1;
                    err_d     = 1'b0;
                    if (job_m_tiles == '0 || job_n_tiles == '0) begin
                        done_d = 1'b1;
                    end else begin
                        cnt_d   = '0;
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (abort) begin
                    state_d = StDrain;
                end else if (eng_done) begin
                    state_d = StRelease;
                end else if (cnt_q == CntMax) begin
                    err_d   = 1'b1;
                    state_d = StDrain;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StRelease: begin
                if (abort) begin
                    state_d = StDrain;
                end else if (!eng_done) begin
                    state_d = StOut;
                end
            end
            StOut: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (res_ready) begin
                    if (walk_last) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        walk_adv = 1'b1;
                        cnt_d    = '0;
                        state_d  = StIssue;
                    end
                end
            end
            StDrain: begin
                if (!eng_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign job_ready   = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign eng_start   = (state_q == StIssue);
    assign res_valid   = (state_q == StOut);
    assign tile_row    = coord.row[TW-1:0];
    assign tile_col    = coord.col[TW-1:0];
    assign res_row     = coord.row[TW-1:0];
    assign res_col     = coord.col[TW-1:0];
    assign res_last    = res_valid && walk_last;
    assign job_done    = done_q;
    assign err_timeout = err_q;

    a_start_only_issue: assert property (@(posedge clk) disable iff (!rst_n)
        eng_start |-> state_q == StIssue);
    a_start_rise_done_low: assert property (@(posedge clk) disable iff (!rst_n)
        $rose(eng_start) |-> !eng_done);
    a_res_stable: assert property (@(posedge clk) disable iff (!rst_n)
        res_valid && !res_ready && !abort |=> res_valid && $stable({res_row, res_col, res_last}));
    a_ready_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
        job_ready |-> !busy);

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Self-checking bench: reactive engine model plus a row-major token scoreboard.
module tb_matmul_tile_scheduler;

    localparam int unsigned TW      = 8;
    localparam int unsigned TIMEOUT = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          job_valid;
    logic          job_ready;
    logic [TW-1:0] job_m_tiles;
    logic [TW-1:0] job_n_tiles;
    logic          abort;
    logic          eng_start;
    logic          eng_done = 1'b0;
    logic [TW-1:0] tile_row;
    logic [TW-1:0] tile_col;
    logic          res_valid;
    logic          res_ready;
    logic [TW-1:0] res_row;
    logic [TW-1:0] res_col;
    logic          res_last;
    logic          job_done;
    logic          busy;
    logic          err_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    int eng_delay = 4;
    int eng_hold  = 0;
    bit eng_mute  = 1'b0;
    int eng_cnt   = 0;
    int eng_hcnt  = 0;

    matmul_tile_scheduler #(
        .TW      (TW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_m_tiles (job_m_tiles),
        .job_n_tiles (job_n_tiles),
        .abort       (abort),
        .eng_start   (eng_start),
        .eng_done    (eng_done),
        .tile_row    (tile_row),
        .tile_col    (tile_col),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_row     (res_row),
        .res_col     (res_col),
        .res_last    (res_last),
        .job_done    (job_done),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // Engine: raise done eng_delay cycles into start, drop it eng_hold cycles after start falls.
    always @(posedge clk) begin
        if (eng_start) begin
            eng_hcnt <= 0;
            if (!eng_done) begin
                eng_cnt <= eng_cnt + 1;
                if (!eng_mute && eng_cnt + 1 >= eng_delay) eng_done <= 1'b1;
            end
        end else begin
            eng_cnt <= 0;
            if (eng_done) begin
                if (eng_hcnt >= eng_hold) eng_done <= 1'b0;
                else eng_hcnt <= eng_hcnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: always ready, 1: random ready, 2: first token stalled for 5 cycles.
    task automatic run_job(input int m, input int n, input int mode);
        int exp_r[$];
        int exp_c[$];
        int cycles     = 0;
        int stall_left = 5;
        bit hs_prev    = 1'b0;
        bit last_prev  = 1'b0;
        bit held       = 1'b0;
        bit done_seen  = 1'b0;
        logic [TW-1:0] h_r, h_c;
        logic          h_l;
        for (int r = 0; r < m; r++)
            for (int c = 0; c < n; c++) begin
                exp_r.push_back(r);
                exp_c.push_back(c);
            end
        check("job_ready_before", job_ready, 1);
        job_m_tiles = TW'(m);
        job_n_tiles = TW'(n);
        job_valid   = 1'b1;
        res_ready   = (mode == 0);
        @(negedge clk);
        job_valid = 1'b0;
        check("err_cleared_on_accept", err_timeout, 0);
        if (m == 0 || n == 0) begin
            check("empty_job_done", job_done, 1);
            check("empty_no_start", eng_start, 0);
            check("empty_stays_idle", job_ready, 1);
            @(negedge clk);
            check("empty_done_one_pulse", job_done, 0);
            check("empty_no_token", res_valid, 0);
            return;
        end
        check("first_start_latency", eng_start, 1);
        h_r = '0; h_c = '0; h_l = 1'b0;
        while (!done_seen && cycles < 400) begin
            if (hs_prev) begin
                if (last_prev) begin
                    check("job_done_after_last", job_done, 1);
                    check("job_ready_after_last", job_ready, 1);
                    done_seen = 1'b1;
                end else begin
                    check("next_start_latency", eng_start, 1);
                end
            end else begin
                check("job_done_quiet", job_done, 0);
            end
            check("start_excl_valid", eng_start & res_valid, 0);
            if (eng_start && exp_r.size() > 0) begin
                check("tile_row", tile_row, exp_r[0]);
                check("tile_col", tile_col, exp_c[0]);
            end
            if (held) begin
                check("held_valid", res_valid, 1);
                check("held_row", res_row, h_r);
                check("held_col", res_col, h_c);
                check("held_last", res_last, h_l);
            end
            if (mode == 1) res_ready = 1'($urandom_range(0, 1));
            else if (mode == 2) begin
                if (res_valid && stall_left > 0) begin
                    res_ready = 1'b0;
                    stall_left--;
                end else res_ready = 1'b1;
            end
            hs_prev = res_valid && res_ready;
            held    = res_valid && !res_ready;
            h_r = res_row; h_c = res_col; h_l = res_last;
            if (hs_prev) begin
                if (exp_r.size() == 0) begin
                    check("extra_token", 1, 0);
                    last_prev = 1'b1;
                end else begin
                    check("tok_row", res_row, exp_r[0]);
                    check("tok_col", res_col, exp_c[0]);
                    last_prev = (exp_r.size() == 1);
                    check("tok_last", res_last, 32'(last_prev));
                    void'(exp_r.pop_front());
                    void'(exp_c.pop_front());
                end
            end
            @(negedge clk);
            cycles++;
        end
        if (!done_seen) check("job_completion_budget", 0, 1);
        check("tokens_outstanding", exp_r.size(), 0);
        res_ready = 1'b0;
    endtask

    initial begin
        int cnt;
        int guard;
        rst_n       = 1'b0;
        job_valid   = 1'b0;
        job_m_tiles = '0;
        job_n_tiles = '0;
        abort       = 1'b0;
        res_ready   = 1'b0;
        #12;
        check("rst_job_ready", job_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_eng_start", eng_start, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_job_done", job_done, 0);
        check("rst_err", err_timeout, 0);
        check("rst_tile", {tile_row, tile_col}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        eng_delay = 4; eng_hold = 0;
        run_job(2, 3, 0);
        run_job(1, 2, 2);
        run_job(0, 5, 0);

        // done arriving on the final permitted ISSUE cycle beats the timeout
        eng_delay = 7;
        run_job(1, 2, 0);
        check("late_done_no_err", err_timeout, 0);
        eng_delay = 4;

        // abort has priority over job_valid in IDLE
        job_m_tiles = 1; job_n_tiles = 1; job_valid = 1'b1; abort = 1'b1;
        @(negedge clk);
        job_valid = 1'b0; abort = 1'b0;
        check("abort_idle_busy", busy, 0);
        check("abort_idle_start", eng_start, 0);
        check("abort_idle_done", job_done, 0);

        // timeout with a silent engine
        eng_mute = 1'b1;
        job_m_tiles = 2; job_n_tiles = 2; job_valid = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
        cnt = 0; guard = 0;
        while (eng_start && guard < 40) begin
            check("to_err_early", err_timeout, 0);
            check("to_done_quiet", job_done, 0);
            cnt++; guard++;
            @(negedge clk);
        end
        check("to_issue_cycles", cnt, TIMEOUT);
        check("to_err_set", err_timeout, 1);
        check("to_drain_busy", busy, 1);
        @(negedge clk);
        check("to_back_idle", job_ready, 1);
        check("to_no_done", job_done, 0);
        check("to_sticky", err_timeout, 1);
        eng_mute = 1'b0;
        run_job(1, 1, 0);

        // abort in ISSUE on tile (0,1), coinciding with done; engine holds done 3 cycles
        eng_delay = 4; eng_hold = 3;
        job_m_tiles = 2; job_n_tiles = 2; job_valid = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
        guard = 0;
        while (!(eng_start && eng_done && tile_col == 1) && guard < 60) begin
            check("ab_pre_done", job_done, 0);
            guard++;
            @(negedge clk);
        end
        check("ab_reached_tile01", guard < 60, 1);
        check("ab_tile_row", tile_row, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_start_dropped", eng_start, 0);
        guard = 0;
        while (eng_done && guard < 20) begin
            check("ab_drain_busy", busy, 1);
            check("ab_drain_no_tok", res_valid, 0);
            check("ab_drain_no_done", job_done, 0);
            guard++;
            @(negedge clk);
        end
        check("ab_done_fell", eng_done, 0);
        check("ab_still_draining", busy, 1);
        @(negedge clk);
        check("ab_idle", job_ready, 1);
        check("ab_no_done", job_done, 0);
        check("ab_no_tok", res_valid, 0);
        res_ready = 1'b0;

        // asynchronous reset while in RELEASE
        eng_delay = 2; eng_hold = 2;
        job_m_tiles = 2; job_n_tiles = 2; job_valid = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
        guard = 0;
        while (!(busy && !eng_start && !res_valid && eng_done) && guard < 30) begin
            guard++;
            @(negedge clk);
        end
        check("rr_reached_release", guard < 30, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rr_job_ready", job_ready, 1);
        check("rr_busy", busy, 0);
        check("rr_start", eng_start, 0);
        check("rr_valid", res_valid, 0);
        check("rr_tile", {tile_row, tile_col}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        guard = 0;
        while (eng_done && guard < 10) begin
            guard++;
            @(negedge clk);
        end
        check("rr_engine_recovered", eng_done, 0);
        eng_hold = 0;
        run_job(1, 1, 0);

        // randomized jobs with back-pressure and varied engine timing
        for (int i = 0; i < 12; i++) begin
            eng_delay = int'($urandom_range(1, 7));
            eng_hold  = int'($urandom_range(0, 2));
            run_job(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1);
            check("rand_no_err", err_timeout, 0);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
